// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the round-robin ALU scheduler and its ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/alu.sv
// RV32 integer ALU with a registered result (one clock edge from operands to rd).
module alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [3:0]      i_op,
  output logic [XLEN-1:0] o_rd
);

  localparam int unsigned SW = $clog2(XLEN);

  logic [SW-1:0]   w_shamt;
  logic [XLEN-1:0] w_res;
  logic [XLEN-1:0] r_rd;

  assign w_shamt = i_rs2[SW-1:0];

  always_comb begin
    w_res = '0;
    case (i_op)
      ALU_ADD:  w_res = i_rs1 + i_rs2;
      ALU_SUB:  w_res = i_rs1 - i_rs2;
      ALU_SLL:  w_res = i_rs1 << w_shamt;
      ALU_SLT:  w_res = {{(XLEN-1){1'b0}}, $signed(i_rs1) < $signed(i_rs2)};
      ALU_SLTU: w_res = {{(XLEN-1){1'b0}}, i_rs1 < i_rs2};
      ALU_XOR:  w_res = i_rs1 ^ i_rs2;
      ALU_SRL:  w_res = i_rs1 >> w_shamt;
      ALU_SRA:  w_res = $unsigned($signed(i_rs1) >>> w_shamt);
      ALU_OR:   w_res = i_rs1 | i_rs2;
      ALU_AND:  w_res = i_rs1 & i_rs2;
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_rd <= '0;
    else         r_rd <= w_res;
  end

  assign o_rd = r_rd;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);

  always_comb begin
    int unsigned w_pos;
    logic        w_found;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = 32'(i_ptr) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      if (!w_found && i_req[IW'(w_pos)]) begin
        w_found            = 1'b1;
        o_idx              = IW'(w_pos);
        o_gnt[IW'(w_pos)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one registered ALU among NREQ requesters: round-robin issue, latency timing and
// per-requester response handshake, with every output driven from a register.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_rs1,
  input  logic [NREQ*XLEN-1:0] req_rs2,
  input  logic [NREQ*4-1:0]    req_op,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [XLEN-1:0]      resp_rd,
  output logic [XLEN-1:0]      alu_rs1,
  output logic [XLEN-1:0]      alu_rs2,
  output logic [3:0]           alu_op,
  input  logic [XLEN-1:0]      alu_rd,
  output logic                 busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_e          r_state;
  logic [NREQ-1:0] r_req_ready;
  logic [NREQ-1:0] r_owner;
  logic [NREQ-1:0] r_resp_valid;
  logic [IW-1:0]   r_gnt_idx;
  logic [IW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_resp_rd;
  logic [XLEN-1:0] r_alu_rs1;
  logic [XLEN-1:0] r_alu_rs2;
  logic [3:0]      r_alu_op;
  logic            r_busy;

  logic [NREQ-1:0] w_arb_gnt;
  logic [IW-1:0]   w_arb_idx;
  logic [IW-1:0]   w_ptr_nxt;
  logic [XLEN-1:0] w_sel_rs1;
  logic [XLEN-1:0] w_sel_rs2;
  logic [3:0]      w_sel_op;
  logic            w_hs;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  // The registered grant is one-hot, so it directly selects the winning operands.
  always_comb begin
    w_sel_rs1 = '0;
    w_sel_rs2 = '0;
    w_sel_op  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_req_ready[i]) begin
        w_sel_rs1 = req_rs1[i*XLEN +: XLEN];
        w_sel_rs2 = req_rs2[i*XLEN +: XLEN];
        w_sel_op  = req_op[i*4 +: 4];
      end
    end
  end

  assign w_hs      = |(req_valid & r_req_ready);
  assign w_ptr_nxt = (r_gnt_idx == IW'(NREQ - 1)) ? '0 : r_gnt_idx + IW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= '0;
      r_owner      <= '0;
      r_resp_valid <= '0;
      r_gnt_idx    <= '0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_resp_rd    <= '0;
      r_alu_rs1    <= '0;
      r_alu_rs2    <= '0;
      r_alu_op     <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_state     <= S_ISSUE;
            r_busy      <= 1'b1;
            r_owner     <= r_req_ready;
            r_req_ready <= '0;
            r_ptr       <= w_ptr_nxt;
            r_alu_rs1   <= w_sel_rs1;
            r_alu_rs2   <= w_sel_rs2;
            r_alu_op    <= w_sel_op;
          end else begin
            r_req_ready <= w_arb_gnt;
            r_gnt_idx   <= w_arb_idx;
          end
        end
        S_ISSUE: begin
          r_cnt   <= CW'(ALU_LAT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_resp_rd    <= alu_rd;
            r_resp_valid <= r_owner;
            r_alu_rs1    <= '0;
            r_alu_rs2    <= '0;
            r_alu_op     <= '0;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          // Arbitrate on the exit edge so a waiting requester can hand off next cycle.
          if (|(resp_ready & r_owner)) begin
            r_resp_valid <= '0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
            r_req_ready  <= w_arb_gnt;
            r_gnt_idx    <= w_arb_idx;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rd    = r_resp_rd;
  assign alu_rs1    = r_alu_rs1;
  assign alu_rs2    = r_alu_rs2;
  assign alu_op     = r_alu_op;
  assign busy       = r_busy;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched + alu: transaction-level model checked every cycle plus directed literals.
module tb_alu_rr_sched;
  import alu_pkg::*;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned ALU_LAT = 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_rs1 = '0;
  logic [NREQ*XLEN-1:0] req_rs2 = '0;
  logic [NREQ*4-1:0]    req_op = '0;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready = '1;
  logic [XLEN-1:0]      resp_rd;
  logic [XLEN-1:0]      alu_rs1;
  logic [XLEN-1:0]      alu_rs2;
  logic [3:0]           alu_op;
  logic [XLEN-1:0]      alu_rd;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_rr_sched #(
    .NREQ    (NREQ),
    .XLEN    (XLEN),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rd    (resp_rd),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_op     (alu_op),
    .alu_rd     (alu_rd),
    .busy       (busy)
  );

  alu #(
    .XLEN (XLEN)
  ) u_alu (
    .i_clk   (clk),
    .i_reset (reset),
    .i_rs1   (alu_rs1),
    .i_rs2   (alu_rs2),
    .i_op    (alu_op),
    .o_rd    (alu_rd)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the instruction definitions.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    int sh = int'(b[4:0]);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SLT:  return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic [NREQ-1:0] arb(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return NREQ'(1) << ((ptr + k) % NREQ);
    end
    return '0;
  endfunction

  // Transaction model: an operation is "age" edges past its handshake.
  int              m_ptr = 0;
  int              m_idx = 0;
  int              m_age = 0;
  bit              m_inflight = 1'b0;
  logic [NREQ-1:0] m_grant = '0;
  logic [31:0]     m_a = '0, m_b = '0, m_res = '0, m_rd = '0;
  logic [3:0]      m_op = '0;

  task automatic model_reset();
    m_ptr = 0; m_idx = 0; m_age = 0; m_inflight = 1'b0; m_grant = '0;
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_rd = '0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    if (!m_inflight) begin
      if ((req_valid & m_grant) != '0) begin
        for (int i = 0; i < NREQ; i++) if (m_grant[i]) m_idx = i;
        m_a        = req_rs1[m_idx*XLEN +: XLEN];
        m_b        = req_rs2[m_idx*XLEN +: XLEN];
        m_op       = req_op[m_idx*4 +: 4];
        m_res      = alu_ref(m_a, m_b, m_op);
        m_ptr      = (m_idx + 1) % NREQ;
        m_grant    = '0;
        m_inflight = 1'b1;
        m_age      = 0;
      end else begin
        m_grant = arb(req_valid, m_ptr);
      end
    end else if (m_age <= int'(ALU_LAT)) begin
      m_age++;
      if (m_age == int'(ALU_LAT) + 1) m_rd = m_res;
    end else if (resp_ready[m_idx]) begin
      m_inflight = 1'b0;
      m_grant    = arb(req_valid, m_ptr);
    end
  endtask

  task automatic compare();
    bit              alu_on;
    logic [NREQ-1:0] exp_rv;
    alu_on = m_inflight && (m_age <= int'(ALU_LAT));
    exp_rv = (m_inflight && m_age > int'(ALU_LAT)) ? NREQ'(1) << m_idx : '0;
    chk("req_ready", req_ready, m_grant);
    chk("busy", busy, m_inflight);
    chk("resp_valid", resp_valid, exp_rv);
    chk("resp_rd", resp_rd, m_rd);
    chk("alu_rs1", alu_rs1, alu_on ? m_a : 32'h0);
    chk("alu_rs2", alu_rs2, alu_on ? m_b : 32'h0);
    chk("alu_op", alu_op, alu_on ? m_op : 4'h0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (reset) model_reset();
      compare();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    req_rs1[i*XLEN +: XLEN] = a;
    req_rs2[i*XLEN +: XLEN] = b;
    req_op[i*4 +: 4]        = op;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    set_req(i, a, b, op);
    req_valid[i] = 1'b1;
    for (int c = 0; c < 20 && !busy; c++) tick();
    chk("issue_handshake", busy, 1'b1);
    req_valid[i] = 1'b0;
  endtask

  task automatic get_resp(input int i, input logic [31:0] exp, input string name);
    for (int c = 0; c < 20 && !resp_valid[i]; c++) tick();
    chk({name, "_valid"}, resp_valid, NREQ'(1) << i);
    chk({name, "_rd"}, resp_rd, exp);
    tick();
  endtask

  initial begin
    int got;
    int last_c;

    // Reset values
    tick();
    tick();
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_rd", resp_rd, 32'h0);
    chk("rst_alu_op", alu_op, 4'h0);
    reset = 1'b0;

    // 1: single request, latency
    set_req(0, 32'd71, 32'd82, ALU_ADD);
    req_valid = 2'b01;
    tick();
    chk("t1_grant", req_ready, 2'b01);
    tick();
    chk("t1_busy", busy, 1'b1);
    req_valid = 2'b00;
    tick();
    chk("t1_alu_rs1", alu_rs1, 32'd71);
    chk("t1_resp_early", resp_valid, 2'b00);
    tick();
    chk("t1_resp_valid", resp_valid, 2'b01);
    chk("t1_resp_rd", resp_rd, 32'd153);
    tick();
    tick();

    // 2: two continuous requesters alternate at full throughput
    apply_reset();
    set_req(0, 32'd16, 32'd3, ALU_SLL);
    set_req(1, 32'd16, 32'd8, ALU_OR);
    req_valid = 2'b11;
    got = 0;
    last_c = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      tick();
      if (resp_valid != '0) begin
        chk("t2_owner", resp_valid, (got % 2 == 0) ? 2'b01 : 2'b10);
        chk("t2_rd", resp_rd, (got % 2 == 0) ? 32'd128 : 32'd24);
        if (got > 0) chk("t2_gap", 64'(c - last_c), 64'(3 + ALU_LAT));
        last_c = c;
        got++;
      end
    end
    chk("t2_count", 64'(got), 64'd4);
    req_valid = 2'b00;
    tick();
    tick();

    // 3: response backpressure holds result and blocks new grants
    resp_ready = 2'b00;
    issue(1, 32'd24, 32'd8, ALU_AND);
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    req_valid[0] = 1'b1;
    for (int c = 0; c < 20 && !resp_valid[1]; c++) tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_hold_valid", resp_valid, 2'b10);
      chk("t3_hold_rd", resp_rd, 32'd8);
      chk("t3_no_grant", req_ready, 2'b00);
    end
    resp_ready = 2'b11;
    req_valid  = 2'b00;
    tick();
    chk("t3_released", resp_valid, 2'b00);
    tick();

    // 4: signed/unsigned compares, arithmetic shift, undefined opcode
    issue(0, 32'd5, 32'd7, 4'b1111);
    get_resp(0, 32'h0, "t4_undef");
    issue(0, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
    get_resp(0, 32'd1, "t4_slt");
    issue(0, 32'hFFFF_FFFF, 32'd1, ALU_SLTU);
    get_resp(0, 32'd0, "t4_sltu");
    issue(0, 32'h8000_0000, 32'd4, ALU_SRA);
    get_resp(0, 32'hF800_0000, "t4_sra");
    tick();

    // 5: reset during WAIT
    issue(0, 32'd5, 32'd6, ALU_ADD);
    tick();
    chk("t5_in_wait", alu_rs1, 32'd5);
    reset = 1'b1;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_resp_valid", resp_valid, 2'b00);
    chk("t5_resp_rd", resp_rd, 32'h0);
    chk("t5_alu_rs1", alu_rs1, 32'h0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_no_resp", resp_valid, 2'b00);
    end
    req_valid = 2'b11;
    tick();
    chk("t5_grant_req0", req_ready, 2'b01);
    req_valid = 2'b00;
    tick();
    tick();

    // 6: one-cycle valid pulse produces no handshake
    req_valid = 2'b01;
    tick();
    chk("t6_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    tick();
    chk("t6_busy", busy, 1'b0);
    chk("t6_grant_gone", req_ready, 2'b00);
    tick();
    chk("t6_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
